// File: rtl/blob_tracker.sv
// rtl/blob_tracker.sv - Cr-threshold blob centroid tracker with 32-cycle restoring divide.
// Optional bounding-box outputs are enabled by defining BLOB_TRACKER_BBOX_EN.
module blob_tracker #(
  parameter int H_ACTIVE  = 1280,
  parameter int V_ACTIVE  = 720,
  parameter int MIN_COUNT = 16
) (
  input  logic        clk_pixel,
  input  logic        sys_rst_pixel,
  input  logic        pix_valid_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic [7:0]  cr_in,
  input  logic [7:0]  cr_lo,
  input  logic [7:0]  cr_hi,
  input  logic        frame_done_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic [19:0] count_out,
  output logic        centroid_valid_out,
  output logic        found_out,
  output logic        dropped_out,
`ifdef BLOB_TRACKER_BBOX_EN
  output logic [10:0] bbox_xmin,
  output logic [10:0] bbox_xmax,
  output logic [9:0]  bbox_ymin,
  output logic [9:0]  bbox_ymax,
`endif
  output logic        busy_out
);
  localparam logic [10:0] LP_H_ACTIVE  = 11'(H_ACTIVE);
  localparam logic [9:0]  LP_V_ACTIVE  = 10'(V_ACTIVE);
  localparam logic [19:0] LP_MIN_COUNT = 20'(MIN_COUNT);

  typedef enum logic {ACCUM, DIVIDE} state_t;
  state_t r_state, w_next_state;

  logic [30:0] r_sum_x;
  logic [29:0] r_sum_y;
  logic [19:0] r_cnt;
  logic [31:0] r_dvd_x, r_dvd_y;
  logic [19:0] r_rem_x, r_rem_y, r_div;
  logic [4:0]  r_step;

  logic        w_mask, w_snap, w_drop, w_last, w_qx, w_qy, w_use;
  logic [30:0] w_sum_x_nxt;
  logic [29:0] w_sum_y_nxt;
  logic [19:0] w_cnt_nxt;
  logic [20:0] w_trial_x, w_trial_y, w_div_ext;
  logic [19:0] w_rem_x_nxt, w_rem_y_nxt;

  assign w_mask = pix_valid_in && (cr_in >= cr_lo) && (cr_in <= cr_hi)
               && (hcount_in < LP_H_ACTIVE) && (vcount_in < LP_V_ACTIVE);

  // Sums including the current pixel, so a pixel coincident with frame_done lands in the snapshot.
  assign w_sum_x_nxt = r_sum_x + (w_mask ? {20'd0, hcount_in} : 31'd0);
  assign w_sum_y_nxt = r_sum_y + (w_mask ? {20'd0, vcount_in} : 30'd0);
  assign w_cnt_nxt   = r_cnt + {19'd0, w_mask};

  assign w_div_ext   = {1'b0, r_div};
  assign w_trial_x   = {r_rem_x, r_dvd_x[31]};
  assign w_trial_y   = {r_rem_y, r_dvd_y[31]};
  assign w_qx        = (w_trial_x >= w_div_ext);
  assign w_qy        = (w_trial_y >= w_div_ext);
  assign w_rem_x_nxt = w_qx ? 20'(w_trial_x - w_div_ext) : w_trial_x[19:0];
  assign w_rem_y_nxt = w_qy ? 20'(w_trial_y - w_div_ext) : w_trial_y[19:0];
  assign w_use       = (r_div >= LP_MIN_COUNT) && (r_div != 20'd0);

  always_ff @(posedge clk_pixel) begin
    if (sys_rst_pixel) r_state <= ACCUM;
    else               r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    busy_out     = 1'b0;
    w_snap       = 1'b0;
    w_drop       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ACCUM: begin
        if (frame_done_in) begin
          w_snap       = 1'b1;
          w_next_state = DIVIDE;
        end
      end
      DIVIDE: begin
        busy_out = 1'b1;
        w_drop   = frame_done_in;
        if (r_step == 5'd31) begin
          w_last       = 1'b1;
          w_next_state = ACCUM;
        end
      end
      default: w_next_state = ACCUM;
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (sys_rst_pixel) begin
      r_sum_x            <= '0;
      r_sum_y            <= '0;
      r_cnt              <= '0;
      r_dvd_x            <= '0;
      r_dvd_y            <= '0;
      r_rem_x            <= '0;
      r_rem_y            <= '0;
      r_div              <= '0;
      r_step             <= '0;
      x_out              <= '0;
      y_out              <= '0;
      count_out          <= '0;
      centroid_valid_out <= 1'b0;
      found_out          <= 1'b0;
      dropped_out        <= 1'b0;
    end else begin
      centroid_valid_out <= 1'b0;
      dropped_out        <= w_drop;
      if (frame_done_in) begin
        r_sum_x <= '0;
        r_sum_y <= '0;
        r_cnt   <= '0;
      end else begin
        r_sum_x <= w_sum_x_nxt;
        r_sum_y <= w_sum_y_nxt;
        r_cnt   <= w_cnt_nxt;
      end
      if (w_snap) begin
        r_dvd_x <= {1'b0, w_sum_x_nxt};
        r_dvd_y <= {2'b0, w_sum_y_nxt};
        r_div   <= w_cnt_nxt;
        r_rem_x <= '0;
        r_rem_y <= '0;
        r_step  <= '0;
      end else if (r_state == DIVIDE) begin
        // Dividend register doubles as the quotient shift register.
        r_dvd_x <= {r_dvd_x[30:0], w_qx};
        r_dvd_y <= {r_dvd_y[30:0], w_qy};
        r_rem_x <= w_rem_x_nxt;
        r_rem_y <= w_rem_y_nxt;
        r_step  <= r_step + 5'd1;
      end
      if (w_last) begin
        centroid_valid_out <= 1'b1;
        count_out          <= r_div;
        found_out          <= (r_div >= LP_MIN_COUNT);
        if (w_use) begin
          x_out <= {r_dvd_x[9:0], w_qx};
          y_out <= {r_dvd_y[8:0], w_qy};
        end
      end
    end
  end

`ifdef BLOB_TRACKER_BBOX_EN
  logic [10:0] r_xmin, r_xmax, r_snap_xmin, r_snap_xmax, w_xmin_nxt, w_xmax_nxt;
  logic [9:0]  r_ymin, r_ymax, r_snap_ymin, r_snap_ymax, w_ymin_nxt, w_ymax_nxt;

  assign w_xmin_nxt = (w_mask && hcount_in < r_xmin) ? hcount_in : r_xmin;
  assign w_xmax_nxt = (w_mask && hcount_in > r_xmax) ? hcount_in : r_xmax;
  assign w_ymin_nxt = (w_mask && vcount_in < r_ymin) ? vcount_in : r_ymin;
  assign w_ymax_nxt = (w_mask && vcount_in > r_ymax) ? vcount_in : r_ymax;

  always_ff @(posedge clk_pixel) begin
    if (sys_rst_pixel) begin
      r_xmin      <= '1;
      r_xmax      <= '0;
      r_ymin      <= '1;
      r_ymax      <= '0;
      r_snap_xmin <= '0;
      r_snap_xmax <= '0;
      r_snap_ymin <= '0;
      r_snap_ymax <= '0;
      bbox_xmin   <= '0;
      bbox_xmax   <= '0;
      bbox_ymin   <= '0;
      bbox_ymax   <= '0;
    end else begin
      if (frame_done_in) begin
        r_xmin <= '1;
        r_xmax <= '0;
        r_ymin <= '1;
        r_ymax <= '0;
      end else begin
        r_xmin <= w_xmin_nxt;
        r_xmax <= w_xmax_nxt;
        r_ymin <= w_ymin_nxt;
        r_ymax <= w_ymax_nxt;
      end
      if (w_snap) begin
        r_snap_xmin <= w_xmin_nxt;
        r_snap_xmax <= w_xmax_nxt;
        r_snap_ymin <= w_ymin_nxt;
        r_snap_ymax <= w_ymax_nxt;
      end
      if (w_last && w_use) begin
        bbox_xmin <= r_snap_xmin;
        bbox_xmax <= r_snap_xmax;
        bbox_ymin <= r_snap_ymin;
        bbox_ymax <= r_snap_ymax;
      end
    end
  end
`endif
endmodule

// File: tb/tb_blob_tracker.sv
// tb/tb_blob_tracker.sv - self-checking bench for blob_tracker (MIN_COUNT=16 and MIN_COUNT=1 instances).
// Bounding-box checks are compiled in when BLOB_TRACKER_BBOX_EN is defined.
module tb_blob_tracker;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pv = 1'b0;
  logic [10:0] hc = '0;
  logic [9:0]  vc = '0;
  logic [7:0]  cr = '0;
  logic [7:0]  lo = 8'd180;
  logic [7:0]  hi = 8'd220;
  logic        fd = 1'b0;

  logic [10:0] x0, x1;
  logic [9:0]  y0, y1;
  logic [19:0] c0, c1;
  logic        v0, v1, f0, f1, d0, d1, b0, b1;
`ifdef BLOB_TRACKER_BBOX_EN
  logic [10:0] bxmin0, bxmax0, bxmin1, bxmax1;
  logic [9:0]  bymin0, bymax0, bymin1, bymax1;
`endif

  always #5 clk = ~clk;

  blob_tracker #(.H_ACTIVE(1280), .V_ACTIVE(720), .MIN_COUNT(16)) dut (
    .clk_pixel(clk), .sys_rst_pixel(rst), .pix_valid_in(pv), .hcount_in(hc), .vcount_in(vc),
    .cr_in(cr), .cr_lo(lo), .cr_hi(hi), .frame_done_in(fd),
    .x_out(x0), .y_out(y0), .count_out(c0), .centroid_valid_out(v0), .found_out(f0),
    .dropped_out(d0),
`ifdef BLOB_TRACKER_BBOX_EN
    .bbox_xmin(bxmin0), .bbox_xmax(bxmax0), .bbox_ymin(bymin0), .bbox_ymax(bymax0),
`endif
    .busy_out(b0));

  blob_tracker #(.H_ACTIVE(1280), .V_ACTIVE(720), .MIN_COUNT(1)) dut1 (
    .clk_pixel(clk), .sys_rst_pixel(rst), .pix_valid_in(pv), .hcount_in(hc), .vcount_in(vc),
    .cr_in(cr), .cr_lo(lo), .cr_hi(hi), .frame_done_in(fd),
    .x_out(x1), .y_out(y1), .count_out(c1), .centroid_valid_out(v1), .found_out(f1),
    .dropped_out(d1),
`ifdef BLOB_TRACKER_BBOX_EN
    .bbox_xmin(bxmin1), .bbox_xmax(bxmax1), .bbox_ymin(bymin1), .bbox_ymax(bymax1),
`endif
    .busy_out(b1));

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: running per-frame sums, the snapshot under division, and held outputs.
  longint m_sx, m_sy, m_n, e_sx, e_sy, e_n;
  int     hx[2], hy[2];
  int     mins[2] = '{16, 1};
  int     m_bb[4], e_bb[4], h_bb[4];

  typedef struct {
    logic        p;
    logic [10:0] h;
    logic [9:0]  v;
    logic [7:0]  c;
    logic [7:0]  l;
    logic [7:0]  u;
    logic [19:0] exp_cnt;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clr_model();
    m_sx = 0; m_sy = 0; m_n = 0;
    m_bb = '{2047, 0, 1023, 0};
  endtask

  task automatic mdl_pix(input logic p, input logic [10:0] h, input logic [9:0] v, input logic [7:0] c);
    if (p && c >= lo && c <= hi && h < 11'd1280 && v < 10'd720) begin
      m_sx += h; m_sy += v; m_n++;
      if (int'(h) < m_bb[0]) m_bb[0] = int'(h);
      if (int'(h) > m_bb[1]) m_bb[1] = int'(h);
      if (int'(v) < m_bb[2]) m_bb[2] = int'(v);
      if (int'(v) > m_bb[3]) m_bb[3] = int'(v);
    end
  endtask

  task automatic drive_pix(input logic p, input logic [10:0] h, input logic [9:0] v, input logic [7:0] c);
    pv = p; hc = h; vc = v; cr = c;
    @(posedge clk); #1;
    mdl_pix(p, h, v, c);
    pv = 1'b0;
  endtask

  task automatic fire_fd(input logic p, input logic [10:0] h, input logic [9:0] v, input logic [7:0] c);
    pv = p; hc = h; vc = v; cr = c; fd = 1'b1;
    @(posedge clk); #1;
    mdl_pix(p, h, v, c);
    e_sx = m_sx; e_sy = m_sy; e_n = m_n; e_bb = m_bb;
    clr_model();
    fd = 1'b0; pv = 1'b0;
  endtask

  task automatic chk_res(input int i, input logic v, input logic [19:0] c, input logic f,
                         input logic [10:0] x, input logic [9:0] y);
    logic found;
    found = (e_n >= mins[i]);
    if (found && e_n != 0) begin
      hx[i] = int'(e_sx / e_n);
      hy[i] = int'(e_sy / e_n);
    end
    chk($sformatf("d%0d_valid", i), 32'(v), 32'd1);
    chk($sformatf("d%0d_count", i), 32'(c), 32'(e_n));
    chk($sformatf("d%0d_found", i), 32'(f), 32'(found));
    chk($sformatf("d%0d_x", i), 32'(x), 32'(hx[i]));
    chk($sformatf("d%0d_y", i), 32'(y), 32'(hy[i]));
  endtask

  // elapsed = clock edges already consumed after the frame_done sampling edge.
  task automatic wait_result(input int elapsed);
    repeat (31 - elapsed) @(posedge clk);
    #1;
    chk("valid_early", 32'({v0, v1}), 32'd0);
    chk("busy_during", 32'({b0, b1}), 32'd3);
    @(posedge clk); #1;
    chk_res(0, v0, c0, f0, x0, y0);
    chk_res(1, v1, c1, f1, x1, y1);
    chk("busy_after", 32'({b0, b1}), 32'd0);
`ifdef BLOB_TRACKER_BBOX_EN
    if (e_n >= 16) h_bb = e_bb;
    chk("bbox", {5'd0, bxmin0, bxmax0[4:0], 1'b0, bymin0[4:0], bymax0[4:0]},
        {5'(0), 11'(h_bb[0]), 5'(h_bb[1]), 1'b0, 5'(h_bb[2]), 5'(h_bb[3])});
`endif
    @(posedge clk); #1;
    chk("valid_pulse_end", 32'({v0, v1}), 32'd0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_d0"}, {x0, y0, v0, f0, d0, b0}, 32'd0);
    chk({name, "_d0c"}, 32'(c0), 32'd0);
    chk({name, "_d1"}, {x1, y1, v1, f1, d1, b1}, 32'd0);
    chk({name, "_d1c"}, 32'(c1), 32'd0);
`ifdef BLOB_TRACKER_BBOX_EN
    chk({name, "_bbox"}, {bxmin0, bymin0, 11'd0}, 32'd0);
    chk({name, "_bboxmax"}, {bxmax0, bymax0, 11'd0}, 32'd0);
`endif
  endtask

  task automatic square();
    lo = 8'd180; hi = 8'd220;
    for (int y = 50; y <= 53; y++)
      for (int x = 100; x <= 103; x++)
        drive_pix(1'b1, 11'(x), 10'(y), 8'd200);
    fire_fd(1'b0, 11'd0, 10'd0, 8'd0);
    wait_result(0);
    chk("sq_count", 32'(c0), 32'd16);
    chk("sq_found", 32'(f0), 32'd1);
    chk("sq_x", 32'(x0), 32'd101);
    chk("sq_y", 32'(y0), 32'd51);
`ifdef BLOB_TRACKER_BBOX_EN
    chk("sq_bbox", {bxmin0[7:0], bxmax0[7:0], bymin0[7:0], bymax0[7:0]},
        {8'd100, 8'd103, 8'd50, 8'd53});
`endif
  endtask

  initial begin
    int seen;
    int np, k;
    vecs[0]  = '{1'b1, 11'd100,  10'd50,  8'd200, 8'd180, 8'd220, 20'd1};
    vecs[1]  = '{1'b0, 11'd100,  10'd50,  8'd200, 8'd180, 8'd220, 20'd0};
    vecs[2]  = '{1'b1, 11'd100,  10'd50,  8'd180, 8'd180, 8'd220, 20'd1};
    vecs[3]  = '{1'b1, 11'd100,  10'd50,  8'd220, 8'd180, 8'd220, 20'd1};
    vecs[4]  = '{1'b1, 11'd100,  10'd50,  8'd179, 8'd180, 8'd220, 20'd0};
    vecs[5]  = '{1'b1, 11'd100,  10'd50,  8'd221, 8'd180, 8'd220, 20'd0};
    vecs[6]  = '{1'b1, 11'd1279, 10'd719, 8'd200, 8'd180, 8'd220, 20'd1};
    vecs[7]  = '{1'b1, 11'd1280, 10'd50,  8'd200, 8'd180, 8'd220, 20'd0};
    vecs[8]  = '{1'b1, 11'd100,  10'd720, 8'd200, 8'd180, 8'd220, 20'd0};
    vecs[9]  = '{1'b1, 11'd100,  10'd50,  8'd150, 8'd200, 8'd100, 20'd0};
    vecs[10] = '{1'b1, 11'd0,    10'd0,   8'd0,   8'd0,   8'd0,   20'd1};
    vecs[11] = '{1'b1, 11'd2047, 10'd50,  8'd200, 8'd180, 8'd220, 20'd0};

    clr_model();
    hx = '{0, 0}; hy = '{0, 0}; h_bb = '{0, 0, 0, 0};
    e_sx = 0; e_sy = 0; e_n = 0; e_bb = '{0, 0, 0, 0};
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    foreach (vecs[i]) begin
      lo = vecs[i].l; hi = vecs[i].u;
      drive_pix(vecs[i].p, vecs[i].h, vecs[i].v, vecs[i].c);
      fire_fd(1'b0, 11'd0, 10'd0, 8'd0);
      wait_result(0);
      chk($sformatf("vec%0d_count", i), 32'(c1), 32'(vecs[i].exp_cnt));
    end

    square();

    for (int x = 200; x < 210; x++) drive_pix(1'b1, 11'(x), 10'd300, 8'd190);
    fire_fd(1'b0, 11'd0, 10'd0, 8'd0);
    wait_result(0);
    chk("ten_found", 32'(f0), 32'd0);
    chk("ten_count", 32'(c0), 32'd10);
    chk("ten_x_held", 32'(x0), 32'd101);
    chk("ten_y_held", 32'(y0), 32'd51);

    fire_fd(1'b0, 11'd0, 10'd0, 8'd0);
    wait_result(0);
    chk("zero_count", 32'(c1), 32'd0);
    chk("zero_found", 32'(f1), 32'd0);

    fire_fd(1'b1, 11'd1279, 10'd719, 8'd200);
    wait_result(0);
    chk("corner_count", 32'(c1), 32'd1);
    chk("corner_x", 32'(x1), 32'd1279);
    chk("corner_y", 32'(y1), 32'd719);

    // Second frame_done 10 cycles into the divide: dropped pulse, first result intact.
    for (int x = 10; x < 30; x++) drive_pix(1'b1, 11'(x), 10'(x + 5), 8'd200);
    fire_fd(1'b0, 11'd0, 10'd0, 8'd0);
    for (int x = 0; x < 9; x++) drive_pix(1'b1, 11'(500 + x), 10'd400, 8'd200);
    fd = 1'b1;
    @(posedge clk); #1;
    fd = 1'b0;
    clr_model();
    chk("drop_pulse", 32'({d0, d1}), 32'd3);
    @(posedge clk); #1;
    chk("drop_end", 32'({d0, d1}), 32'd0);
    wait_result(11);
    square();

    // Reset during the divide: no valid pulse, all outputs zero, then clean recovery.
    for (int x = 0; x < 20; x++) drive_pix(1'b1, 11'(600 + x), 10'd100, 8'd200);
    fire_fd(1'b0, 11'd0, 10'd0, 8'd0);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_zero("midreset");
    clr_model();
    hx = '{0, 0}; hy = '{0, 0}; h_bb = '{0, 0, 0, 0};
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (v0 || v1) seen++;
    end
    chk("midreset_no_valid", 32'(seen), 32'd0);
    square();

    // Randomised frames, with next-frame pixels overlapping the divide.
    for (int f = 0; f < 20; f++) begin
      lo = 8'($urandom_range(0, 120));
      hi = 8'(int'(lo) + $urandom_range(0, 135));
      np = $urandom_range(0, 40);
      for (int p = 0; p < np; p++)
        drive_pix(1'($urandom_range(0, 9) != 0), 11'($urandom_range(0, 1300)),
                  10'($urandom_range(0, 740)), 8'($urandom_range(0, 255)));
      fire_fd(1'($urandom_range(0, 1)), 11'($urandom_range(0, 1300)),
              10'($urandom_range(0, 740)), 8'($urandom_range(0, 255)));
      k = $urandom_range(0, 20);
      for (int p = 0; p < k; p++)
        drive_pix(1'b1, 11'($urandom_range(0, 1279)), 10'($urandom_range(0, 719)),
                  8'($urandom_range(0, 255)));
      wait_result(k);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/blob_tracker.md
BLOB_TRACKER -- requirements
Module: blob_tracker

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 720, active lines per frame.
REQ-003 SHALL have parameter MIN_COUNT, default 16, minimum masked pixels for a valid detection.
REQ-004 SHALL have port clk_pixel  input  1  pixel clock; single clock domain.
REQ-005 SHALL have port sys_rst_pixel  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port pix_valid_in  input  1  pixel qualifier.
REQ-007 SHALL have port hcount_in  input  11  pixel x coordinate.
REQ-008 SHALL have port vcount_in  input  10  pixel y coordinate.
REQ-009 SHALL have port cr_in  input  8  offset-binary Cr of the pixel.
REQ-010 SHALL have ports cr_lo, cr_hi  input  8 each  inclusive Cr threshold window.
REQ-011 SHALL have port frame_done_in  input  1  one-cycle pulse closing the current frame.
REQ-012 SHALL have ports x_out (11), y_out (10), count_out (20)  output  centroid and masked-pixel count.
REQ-013 SHALL have ports centroid_valid_out, found_out, dropped_out, busy_out  output  1 each.

Function
REQ-014 SHALL define mask = pix_valid_in AND cr_lo <= cr_in <= cr_hi AND hcount_in < H_ACTIVE AND vcount_in < V_ACTIVE.
REQ-015 SHALL on each masked cycle add hcount_in to sum_x (31 b), vcount_in to sum_y (30 b), and 1 to cnt (20 b); no overflow is possible at default parameters.
REQ-016 SHALL implement FSM states ACCUM and DIVIDE; reset state ACCUM.
REQ-017 SHALL in ACCUM, on frame_done_in, snapshot sum_x/sum_y/cnt (including a masked pixel in that same cycle), clear the accumulators, and enter DIVIDE on the next cycle.
REQ-018 SHALL keep accumulating the following frame into the cleared accumulators while in DIVIDE.
REQ-019 SHALL in DIVIDE run two parallel restoring dividers (sum_x/cnt, sum_y/cnt), one quotient bit per cycle, for exactly 32 cycles, then return to ACCUM.
REQ-020 SHALL, for frame_done_in sampled at cycle T, pulse centroid_valid_out high for exactly one cycle at T+33.
REQ-021 SHALL at T+33 load count_out with the snapshot count and set found_out = (count >= MIN_COUNT).
REQ-022 SHALL at T+33 load x_out/y_out with the truncated quotients only when found_out is 1; otherwise hold previous values.
REQ-023 SHALL never use a quotient when count is 0 (division by zero result discarded).
REQ-024 SHALL, on frame_done_in while in DIVIDE, discard the in-progress accumulators (clear them), keep the running division undisturbed, and pulse dropped_out for one cycle.
REQ-025 SHALL drive busy_out high exactly while in DIVIDE.

Reset
REQ-026 SHALL on sys_rst_pixel force state ACCUM, clear all accumulators, snapshots and divider state.
REQ-027 SHALL on reset drive x_out=0, y_out=0, count_out=0, centroid_valid_out=0, found_out=0, dropped_out=0, busy_out=0.
REQ-028 SHALL abort a division in progress on reset mid-DIVIDE with no centroid_valid_out pulse.

Configuration
REQ-029 SHALL, when BLOB_TRACKER_BBOX_EN is defined, add outputs bbox_xmin/bbox_xmax (11 b) and bbox_ymin/bbox_ymax (10 b), tracking min/max coordinates of masked pixels per frame, snapshotted at frame_done_in and published at T+33 alongside the centroid, updated only when found_out is 1, reset to 0.
REQ-030 SHALL, when BLOB_TRACKER_BBOX_EN is not defined, omit the bbox ports and logic entirely; all other behaviour is identical.

Verification
REQ-031 SHALL test a 4x4 masked square at x=100..103, y=50..53 (cr=200, window 180..220), frame_done -> at T+33 valid=1, found=1, count=16, x_out=101, y_out=51.
REQ-032 SHALL test 10 masked pixels, MIN_COUNT=16 -> found=0, count=10, x_out/y_out unchanged from the prior frame.
REQ-033 SHALL test zero masked pixels -> valid pulse at T+33, count=0, found=0, no X/garbage on x_out/y_out.
REQ-034 SHALL test a second frame_done 10 cycles after the first -> dropped_out pulse at that cycle, first result still correct at T+33, next frame's sums start from zero.
REQ-035 SHALL test a masked pixel coincident with frame_done at (1279,719) on an otherwise empty frame with MIN_COUNT=1 -> count=1, x_out=1279, y_out=719.
REQ-036 SHALL test reset asserted at T+15 -> no valid pulse, all outputs 0, next frame computes correctly; with BLOB_TRACKER_BBOX_EN, the REQ-031 case yields bbox 100/103/50/53.
